// File: rtl/ps2_key_receiver.sv
// PS/2 keyboard receiver: synchronizes the keyboard lines, deframes 11-bit frames
// and tracks the held key as keycode/extended/detect.
module ps2_key_receiver #(
    parameter int TIMEOUT_CYCLES = 10000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       PS2C,
    input  logic       PS2D,
    output logic [7:0] keycode,
    output logic       extended,
    output logic       detect,
    output logic       frame_err
);
    // state | meaning
    // IDLE  | waiting for a start bit (falling PS2C with PS2D low)
    // RECV  | shifting in data, parity and stop bits under a timeout watch

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYCLES);

    typedef enum logic {IDLE, RECV} state_t;

    state_t        state;
    logic          c_s1, c_s2, c_s3;
    logic          d_s1, d_s2;
    logic [3:0]    bit_cnt;
    logic [TW-1:0] tmo_cnt;
    logic [8:0]    shreg;
    logic [7:0]    rx_byte;
    logic          byte_vld;
    logic          ext_pending, brk_pending;
    logic          relaunch;
    logic          fall;

    assign fall = c_s3 & ~c_s2;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            c_s1 <= 1'b1;
            c_s2 <= 1'b1;
            c_s3 <= 1'b1;
            d_s1 <= 1'b1;
            d_s2 <= 1'b1;
        end else begin
            c_s1 <= PS2C;
            c_s2 <= c_s1;
            c_s3 <= c_s2;
            d_s1 <= PS2D;
            d_s2 <= d_s1;
        end
    end

    // Timeout runs as a down-counter reloaded on every PS2C falling edge.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            tmo_cnt   <= '0;
            shreg     <= '0;
            rx_byte   <= '0;
            byte_vld  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            byte_vld  <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (fall && !d_s2) begin
                        state   <= RECV;
                        bit_cnt <= 4'd1;
                        tmo_cnt <= TMO_LOAD;
                    end
                end
                RECV: begin
                    if (fall) begin
                        tmo_cnt <= TMO_LOAD;
                        if (bit_cnt == 4'd10) begin
                            state   <= IDLE;
                            bit_cnt <= '0;
                            if (d_s2 && (^shreg)) begin
                                byte_vld <= 1'b1;
                                rx_byte  <= shreg[7:0];
                            end else begin
                                frame_err <= 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                            shreg   <= {d_s2, shreg[8:1]};
                        end
                    end else if (tmo_cnt == '0) begin
                        state     <= IDLE;
                        bit_cnt   <= '0;
                        frame_err <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A make of a different key drops detect for one cycle so the strobe stage re-fires.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            keycode     <= '0;
            extended    <= 1'b0;
            detect      <= 1'b0;
            ext_pending <= 1'b0;
            brk_pending <= 1'b0;
            relaunch    <= 1'b0;
        end else if (byte_vld) begin
            if (rx_byte == 8'hE0) begin
                ext_pending <= 1'b1;
            end else if (rx_byte == 8'hF0) begin
                brk_pending <= 1'b1;
            end else begin
                ext_pending <= 1'b0;
                brk_pending <= 1'b0;
                if (brk_pending) begin
                    if (rx_byte == keycode && ext_pending == extended)
                        detect <= 1'b0;
                end else if (!detect) begin
                    keycode  <= rx_byte;
                    extended <= ext_pending;
                    detect   <= 1'b1;
                end else if (rx_byte != keycode || ext_pending != extended) begin
                    keycode  <= rx_byte;
                    extended <= ext_pending;
                    detect   <= 1'b0;
                    relaunch <= 1'b1;
                end
            end
        end else if (relaunch) begin
            detect   <= 1'b1;
            relaunch <= 1'b0;
        end
    end
endmodule
